// File: rtl/motor_link_pkg.sv
// Shared constants, state encoding and frame packing for the motor UART link.
// Latency: none (declarations and a combinational helper only).
// Backpressure: n/a.
package motor_link_pkg;

    localparam logic [7:0] POLL_BYTE   = 8'h0F;
    localparam int         FRAME_BYTES = 5;
    localparam int         REPLY_BYTES = 4;
    localparam int         FRAME_W     = 8 * FRAME_BYTES;

    localparam int DIV_W  = 15;
    localparam int STEP_W = 15;
    localparam int IDX_W  = 4;
    localparam int STAT_W = 5;

    localparam int OFF_IDX   = 0;
    localparam int OFF_DIV   = 4;
    localparam int OFF_STEPS = 19;
    localparam int OFF_DIR   = 34;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_BYTE  = 3'd1,
        TX_WAIT  = 3'd2,
        GAP      = 3'd3,
        RX_REPLY = 3'd4
    } linkState_t;

    // Builds the 40-bit move frame; the top five bits are always zero.
    function automatic logic [FRAME_W-1:0] packFrame(
        input logic [IDX_W-1:0]  idx,
        input logic [DIV_W-1:0]  divider,
        input logic [STEP_W-1:0] steps,
        input logic              dir
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[OFF_IDX   +: IDX_W]  = idx;
        f[OFF_DIV   +: DIV_W]  = divider;
        f[OFF_STEPS +: STEP_W] = steps;
        f[OFF_DIR]             = dir;
        return f;
    endfunction

endpackage

// File: rtl/motor_link_status_rx.sv
// Collects the 4-byte status reply: rx_ready edge detect, per-byte tag check, timeout.
// Latency: done/err are combinational in the cycle the last/bad byte edge or timeout is seen.
// Backpressure: none; bytes arriving while not armed are dropped.
module motor_link_status_rx
    import motor_link_pkg::*;
#(
    parameter logic [19:0] REPLY_TIMEOUT = 20'd50000
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                start,
    input  logic [7:0]          rx_data,
    input  logic                rx_ready,
    output logic                done,
    output logic                err,
    output logic [2*STAT_W-1:0] replyPending,
    output logic [2*STAT_W-1:0] replyTerm
);

    logic              active;
    logic [1:0]        byteIdx;
    logic [19:0]       timer;
    logic              rxReadyQ;
    logic [STAT_W-1:0] d0, d1, d2;
    logic              rxEdge;
    logic              tagOk;

    // Edge detect, tag check and result assembly; the last byte is used straight off the bus.
    always_comb begin
        rxEdge       = rx_ready & ~rxReadyQ;
        tagOk        = (rx_data[7:6] == byteIdx) && !rx_data[5];
        done         = active && rxEdge && tagOk && (byteIdx == 2'(REPLY_BYTES - 1));
        err          = active && ((rxEdge && !tagOk) || (!rxEdge && timer == 20'd0));
        replyPending = {d1, d0};
        replyTerm    = {rx_data[STAT_W-1:0], d2};
    end

    // Reply tracking: arm on start, store good bytes, disarm on completion or error.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            byteIdx  <= 2'd0;
            timer    <= 20'd0;
            rxReadyQ <= 1'b0;
            d0       <= '0;
            d1       <= '0;
            d2       <= '0;
        end else begin
            rxReadyQ <= rx_ready;
            if (start) begin
                active  <= 1'b1;
                byteIdx <= 2'd0;
                timer   <= REPLY_TIMEOUT;
            end else if (active) begin
                if (done || err) begin
                    active <= 1'b0;
                end else begin
                    timer <= timer - 20'd1;
                    if (rxEdge) begin
                        case (byteIdx)
                            2'd0:    d0 <= rx_data[STAT_W-1:0];
                            2'd1:    d1 <= rx_data[STAT_W-1:0];
                            default: d2 <= rx_data[STAT_W-1:0];
                        endcase
                        byteIdx <= byteIdx + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/motor_link_master.sv
// Host end of the motor UART link: frames move commands, polls status, tracks busy motors.
// Latency: tx_start 2 cycles after acceptance; status/err registered 1 cycle after the deciding byte.
// Backpressure: cmd_ready low outside IDLE, while a poll is due, or while the target motor is busy.
module motor_link_master
    import motor_link_pkg::*;
#(
    parameter int          N_MOTORS      = 10,
    parameter logic [15:0] BYTE_GAP      = 16'd64,
    parameter logic [19:0] POLL_PERIOD   = 20'd250000,
    parameter logic [19:0] REPLY_TIMEOUT = 20'd50000
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IDX_W-1:0]    cmd_idx,
    input  logic [DIV_W-1:0]    cmd_divider,
    input  logic [STEP_W-1:0]   cmd_steps,
    input  logic                cmd_dir,
    output logic                cmd_rej,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    input  logic                tx_busy,
    input  logic [7:0]          rx_data,
    input  logic                rx_ready,
    output logic [2*STAT_W-1:0] pending,
    output logic [2*STAT_W-1:0] term,
    output logic                status_valid,
    output logic                link_err
);

    localparam logic [IDX_W:0] NMOT = (IDX_W + 1)'(N_MOTORS);

    linkState_t          state, nextState;
    logic                pollDue;
    logic [19:0]         pollTimer;
    logic [FRAME_W-1:0]  frame;
    logic [2:0]          byteCnt;
    logic                isPoll;
    logic                txWaitFirst;
    logic [15:0]         gapCnt;
    logic [2*STAT_W-1:0] pendingReg, termReg;
    logic                txStartReg, cmdRejReg, statusValidReg, linkErrReg;
    logic [7:0]          txDataReg;

    logic                rxStart, rxDone, rxErr;
    logic [2*STAT_W-1:0] rxPending, rxTerm;

    logic                idxOk, targetBusy, acceptCmd, lastByte, pollClear;
    logic [15:0]         pendingPad, oneHot;

    // Acceptance decode; out-of-range indices are always accepted so they can be rejected.
    always_comb begin
        idxOk      = {1'b0, cmd_idx} < NMOT;
        pendingPad = {{(16 - 2*STAT_W){1'b0}}, pendingReg};
        oneHot     = 16'd1 << cmd_idx;
        targetBusy = idxOk && pendingPad[cmd_idx];
        cmd_ready  = (state == IDLE) && !pollDue && !targetBusy;
        acceptCmd  = cmd_valid && cmd_ready;
        lastByte   = (byteCnt == 3'(FRAME_BYTES - 1));
        pollClear  = (state == GAP) && (gapCnt == 16'd0) && isPoll;
    end

    // Next-state logic; a due poll always wins over a pending command.
    always_comb begin
        nextState = state;
        rxStart   = 1'b0;
        case (state)
            IDLE: begin
                if (pollDue || (acceptCmd && idxOk)) nextState = TX_BYTE;
            end
            TX_BYTE: begin
                if (!tx_busy) nextState = TX_WAIT;
            end
            TX_WAIT: begin
                if (!txWaitFirst && !tx_busy) nextState = GAP;
            end
            GAP: begin
                if (gapCnt == 16'd0) begin
                    if (isPoll) begin
                        nextState = RX_REPLY;
                        rxStart   = 1'b1;
                    end else if (lastByte) begin
                        nextState = IDLE;
                    end else begin
                        nextState = TX_BYTE;
                    end
                end
            end
            RX_REPLY: begin
                if (rxDone || rxErr) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Poll timer: starts expired so the first poll leaves right after reset; due flag never stacks.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pollTimer <= 20'd0;
            pollDue   <= 1'b0;
        end else if (pollTimer == 20'd0) begin
            pollTimer <= POLL_PERIOD - 20'd1;
            pollDue   <= 1'b1;
        end else begin
            pollTimer <= pollTimer - 20'd1;
            if (pollClear) pollDue <= 1'b0;
        end
    end

    // State register plus framing datapath, shadow pending bits and registered output pulses.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            frame          <= '0;
            byteCnt        <= 3'd0;
            isPoll         <= 1'b0;
            txWaitFirst    <= 1'b0;
            gapCnt         <= 16'd0;
            pendingReg     <= '1;
            termReg        <= '0;
            txStartReg     <= 1'b0;
            txDataReg      <= 8'd0;
            cmdRejReg      <= 1'b0;
            statusValidReg <= 1'b0;
            linkErrReg     <= 1'b0;
        end else begin
            state          <= nextState;
            txStartReg     <= 1'b0;
            cmdRejReg      <= 1'b0;
            statusValidReg <= 1'b0;
            linkErrReg     <= rxErr;
            case (state)
                IDLE: begin
                    if (pollDue) begin
                        isPoll  <= 1'b1;
                        byteCnt <= 3'd0;
                    end else if (acceptCmd) begin
                        if (idxOk) begin
                            isPoll     <= 1'b0;
                            byteCnt    <= 3'd0;
                            frame      <= packFrame(cmd_idx, cmd_divider, cmd_steps, cmd_dir);
                            pendingReg <= pendingReg | oneHot[2*STAT_W-1:0];
                        end else begin
                            cmdRejReg <= 1'b1;
                        end
                    end
                end
                TX_BYTE: begin
                    if (!tx_busy) begin
                        txStartReg  <= 1'b1;
                        txDataReg   <= isPoll ? POLL_BYTE : frame[7:0];
                        txWaitFirst <= 1'b1;
                    end
                end
                TX_WAIT: begin
                    txWaitFirst <= 1'b0;
                    if (!txWaitFirst && !tx_busy) gapCnt <= BYTE_GAP;
                end
                GAP: begin
                    if (gapCnt != 16'd0) begin
                        gapCnt <= gapCnt - 16'd1;
                    end else if (!isPoll && !lastByte) begin
                        byteCnt <= byteCnt + 3'd1;
                        frame   <= frame >> 8;
                    end
                end
                RX_REPLY: begin
                    if (rxDone) begin
                        pendingReg     <= rxPending;
                        termReg        <= rxTerm;
                        statusValidReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    motor_link_status_rx #(
        .REPLY_TIMEOUT (REPLY_TIMEOUT)
    ) u_status_rx (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .start        (rxStart),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .done         (rxDone),
        .err          (rxErr),
        .replyPending (rxPending),
        .replyTerm    (rxTerm)
    );

    assign tx_start     = txStartReg;
    assign tx_data      = txDataReg;
    assign cmd_rej      = cmdRejReg;
    assign pending      = pendingReg;
    assign term         = termReg;
    assign status_valid = statusValidReg;
    assign link_err     = linkErrReg;

endmodule

// File: tb/tb_motor_link_master.sv
// Directed bench for motor_link_master with a UART transmitter model and hand-built replies.
// Latency: n/a.
// Backpressure: n/a.
module tb_motor_link_master;

    localparam int BUSY_LEN = 20;
    localparam int GAP_LEN  = 8;
    localparam int TMO      = 300;
    localparam int POLL_P   = 4000;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_idx;
    logic [14:0] cmd_divider;
    logic [14:0] cmd_steps;
    logic        cmd_dir;
    logic        cmd_rej;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [9:0]  pending;
    logic [9:0]  term;
    logic        status_valid;
    logic        link_err;

    motor_link_master #(
        .N_MOTORS      (10),
        .BYTE_GAP      (16'(GAP_LEN)),
        .POLL_PERIOD   (20'(POLL_P)),
        .REPLY_TIMEOUT (20'(TMO))
    ) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_idx      (cmd_idx),
        .cmd_divider  (cmd_divider),
        .cmd_steps    (cmd_steps),
        .cmd_dir      (cmd_dir),
        .cmd_rej      (cmd_rej),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .pending      (pending),
        .term         (term),
        .status_valid (status_valid),
        .link_err     (link_err)
    );

    always #5 CLK = ~CLK;

    int         cyc;
    int         nCompared  = 0;
    int         nMismatch  = 0;
    logic [7:0] txLog[$];
    int         txTime[$];
    int         busyCnt;
    int         svCnt, errCnt, rejCnt, startsInReset;
    int         errCyc, rxCyc;
    logic [9:0] svPending, svTerm;
    bit         acc;

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic checkEq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model and pulse monitor, all sampled on the falling edge.
    initial begin
        tx_busy = 1'b0; busyCnt = 0;
        svCnt = 0; errCnt = 0; rejCnt = 0; startsInReset = 0;
        errCyc = 0; svPending = '0; svTerm = '0;
        forever begin
            @(negedge CLK);
            if (busyCnt != 0) begin
                busyCnt--;
                if (busyCnt == 0) tx_busy = 1'b0;
            end
            if (tx_start) begin
                if (!reset_n) startsInReset++;
                txLog.push_back(tx_data);
                txTime.push_back(cyc);
                tx_busy = 1'b1;
                busyCnt = BUSY_LEN;
            end
            if (status_valid) begin
                svCnt++; svPending = pending; svTerm = term;
            end
            if (link_err) begin
                errCnt++; errCyc = cyc;
            end
            if (cmd_rej) rejCnt++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Caller is at a falling edge; holds the command until accepted or maxCyc expires.
    task automatic offerCmd(input logic [3:0] idx, input logic [14:0] dv, input logic [14:0] st,
                            input logic dr, input int maxCyc, output bit accepted);
        accepted = 1'b0;
        cmd_idx = idx; cmd_divider = dv; cmd_steps = st; cmd_dir = dr; cmd_valid = 1'b1;
        for (int i = 0; i < maxCyc && !accepted; i++) begin
            #1;
            if (cmd_ready) accepted = 1'b1;
            @(negedge CLK);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic waitTx(input int n, input int maxCyc, input string tag);
        int i;
        i = 0;
        while (txLog.size() < n && i < maxCyc) begin
            @(negedge CLK); #2;
            i++;
        end
        checkEq(tag, 40'(txLog.size() >= n), 40'd1);
    endtask

    task automatic awaitPoll(input int base, input int maxCyc, input string tag);
        waitTx(base + 1, maxCyc, {tag, "_seen"});
        if (txLog.size() > base) begin
            checkEq({tag, "_byte"}, 40'(txLog[base]), 40'h0F);
            while (cyc < txTime[base] + BUSY_LEN + GAP_LEN + 6) @(negedge CLK);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge CLK);
        rx_data = b; rx_ready = 1'b1; rxCyc = cyc;
        repeat (3) @(negedge CLK);
        rx_ready = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic checkFrame(input int base, input logic [39:0] exp, input string tag);
        logic [39:0] e;
        int d;
        e = exp;
        for (int i = 0; i < 5; i++) begin
            if (txLog.size() > base + i)
                checkEq($sformatf("%s_b%0d", tag, i), 40'(txLog[base + i]), 40'(e[8*i +: 8]));
            if (i > 0 && txTime.size() > base + i) begin
                d = txTime[base + i] - txTime[base + i - 1];
                checkEq($sformatf("%s_gap%0d", tag, i),
                        40'(d >= BUSY_LEN + GAP_LEN && d <= BUSY_LEN + GAP_LEN + 6), 40'd1);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_idx = '0; cmd_divider = '0; cmd_steps = '0;
        cmd_dir = 1'b0; rx_data = '0; rx_ready = 1'b0;
        repeat (3) @(negedge CLK);
        checkEq("rst_pending", 40'(pending), 40'h3FF);
        checkEq("rst_term", 40'(term), 40'h0);
        checkEq("rst_tx_start", 40'(tx_start), 40'h0);
        checkEq("rst_tx_data", 40'(tx_data), 40'h0);
        checkEq("rst_cmd_ready", 40'(cmd_ready), 40'h0);
        checkEq("rst_pulses", 40'({status_valid, link_err, cmd_rej}), 40'h0);
        reset_n = 1'b1;

        // First poll goes out at once; good reply updates status.
        awaitPoll(0, 50, "poll1");
        checkEq("poll1_prompt", 40'(txTime[0] <= 5), 40'd1);
        sendByte(8'h05); sendByte(8'h5F); sendByte(8'h81); sendByte(8'hC0);
        repeat (3) @(negedge CLK);
        checkEq("st1_count", 40'(svCnt), 40'd1);
        checkEq("st1_pending", 40'(svPending), 40'h3E5);
        checkEq("st1_term", 40'(svTerm), 40'h001);
        checkEq("st1_no_err", 40'(errCnt), 40'd0);

        // Busy motor 0 is held off; motor 3 is free and goes out as b0..b4.
        offerCmd(4'd0, 15'h1234, 15'h0ABC, 1'b1, 10, acc);
        checkEq("busy_idx0_held", 40'(acc), 40'd0);
        offerCmd(4'd3, 15'h1234, 15'h0ABC, 1'b1, 10, acc);
        checkEq("cmd1_accepted", 40'(acc), 40'd1);
        checkEq("cmd1_shadow", 40'(pending), 40'h3ED);
        waitTx(6, 800, "cmd1_bytes");
        checkFrame(1, 40'h04_55E1_2343, "cmd1");
        repeat (BUSY_LEN + GAP_LEN + 10) @(negedge CLK);

        // Second command to the same motor before a poll is blocked.
        offerCmd(4'd3, 15'h1234, 15'h0ABC, 1'b1, 30, acc);
        checkEq("cmd2_blocked", 40'(acc), 40'd0);

        // Out-of-range indices are consumed and rejected without transmission.
        offerCmd(4'd12, 15'h0001, 15'h0001, 1'b0, 5, acc);
        checkEq("rej12_accepted", 40'(acc), 40'd1);
        offerCmd(4'd10, 15'h0001, 15'h0001, 1'b0, 5, acc);
        checkEq("rej10_accepted", 40'(acc), 40'd1);
        repeat (20) @(negedge CLK);
        checkEq("rej_count", 40'(rejCnt), 40'd2);
        checkEq("rej_no_tx", 40'(txLog.size()), 40'd6);
        checkEq("rej_pending", 40'(pending), 40'h3ED);

        // Held command to motor 3 goes out only after a reply clears it.
        fork
            offerCmd(4'd3, 15'h1234, 15'h0ABC, 1'b1, 6000, acc);
            begin
                awaitPoll(6, 4500, "poll2");
                sendByte(8'h00); sendByte(8'h40); sendByte(8'h9F); sendByte(8'hD5);
            end
        join
        checkEq("cmd3_accepted", 40'(acc), 40'd1);
        waitTx(12, 800, "cmd3_bytes");
        checkFrame(7, 40'h04_55E1_2343, "cmd3");
        checkEq("st2_pending", 40'(svPending), 40'h000);
        checkEq("st2_term", 40'(svTerm), 40'h2BF);
        checkEq("cmd3_shadow", 40'(pending), 40'h008);
        repeat (BUSY_LEN + GAP_LEN + 10) @(negedge CLK);

        // Poll with no reply times out and leaves status alone.
        awaitPoll(12, 4500, "poll3");
        for (int i = 0; i < 600 && errCnt < 1; i++) @(negedge CLK);
        checkEq("tmo_err", 40'(errCnt), 40'd1);
        checkEq("tmo_window", 40'((errCyc - txTime[12]) >= BUSY_LEN + GAP_LEN + TMO &&
                                  (errCyc - txTime[12]) <= BUSY_LEN + GAP_LEN + TMO + 8), 40'd1);
        checkEq("tmo_pending", 40'(pending), 40'h008);
        checkEq("tmo_term", 40'(term), 40'h2BF);

        // Bad tag on the second reply byte.
        awaitPoll(13, 4500, "poll4");
        sendByte(8'h05); sendByte(8'h9F);
        checkEq("tag_err", 40'(errCnt), 40'd2);
        checkEq("tag_err_when", 40'((errCyc - rxCyc) >= 1 && (errCyc - rxCyc) <= 2), 40'd1);
        checkEq("tag_no_status", 40'(svCnt), 40'd2);
        checkEq("tag_pending", 40'(pending), 40'h008);
        checkEq("tag_term", 40'(term), 40'h2BF);

        // Command offered in the very cycle a poll becomes due: poll first.
        while (cyc < 1 + 4 * POLL_P) @(negedge CLK);
        fork
            offerCmd(4'd9, 15'h7FFF, 15'h7FFF, 1'b1, 2000, acc);
            begin
                awaitPoll(14, 50, "poll5");
                sendByte(8'h00); sendByte(8'h40); sendByte(8'h80); sendByte(8'hC0);
            end
        join
        checkEq("cmd4_accepted", 40'(acc), 40'd1);
        waitTx(20, 800, "cmd4_bytes");
        checkFrame(15, 40'h07_FFFF_FFF9, "cmd4");
        checkEq("st3_pending", 40'(svPending), 40'h000);
        checkEq("cmd4_shadow", 40'(pending), 40'h200);
        repeat (BUSY_LEN + GAP_LEN + 10) @(negedge CLK);

        // Reset while b2 is being started aborts the frame.
        offerCmd(4'd3, 15'h1234, 15'h0ABC, 1'b1, 10, acc);
        checkEq("cmd5_accepted", 40'(acc), 40'd1);
        waitTx(23, 400, "cmd5_b2");
        reset_n = 1'b0;
        #1;
        checkEq("mid_rst_tx_start", 40'(tx_start), 40'h0);
        checkEq("mid_rst_tx_data", 40'(tx_data), 40'h0);
        checkEq("mid_rst_pending", 40'(pending), 40'h3FF);
        checkEq("mid_rst_term", 40'(term), 40'h0);
        checkEq("mid_rst_ready", 40'(cmd_ready), 40'h0);
        repeat (5) @(negedge CLK);
        checkEq("mid_rst_no_start", 40'(startsInReset), 40'd0);
        checkEq("mid_rst_no_bytes", 40'(txLog.size()), 40'd23);
        reset_n = 1'b1;
        waitTx(24, 100, "post_rst_tx");
        if (txLog.size() > 23) checkEq("post_rst_poll", 40'(txLog[23]), 40'h0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/motor_link_master.md
Name: motor_link_master

Overview:
- Host-side end of the motor-controller UART command link. Sits on the host FPGA between the host command logic and a byte-level UART (async_transmitter/async_receiver, 115200 baud at 25 MHz).
- Serialises motor move commands into the 5-byte frame the controller decodes.
- Periodically sends the status-poll byte and parses the 4-byte status reply into per-motor pending and endstop vectors.
- Tracks a shadow pending vector so that no command is sent to a motor that is still busy.

Parameters:
- N_MOTORS, 10, number of motors; command index range is 0..N_MOTORS-1.
- BYTE_GAP, 16'd64, idle cycles inserted after each transmitted byte finishes (tx_busy falls).
- POLL_PERIOD, 20'd250000, cycles between status polls (10 ms at 25 MHz).
- REPLY_TIMEOUT, 20'd50000, cycles allowed for a complete 4-byte reply after the poll byte finishes.

Ports:
- CLK  in  1  system clock, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  the command is accepted on this cycle if cmd_valid is also high.
- cmd_idx  in  4  target motor index.
- cmd_divider  in  15  step-rate divider.
- cmd_steps  in  15  number of steps.
- cmd_dir  in  1  direction.
- cmd_rej  out  1  one-cycle pulse: command consumed but dropped because cmd_idx >= N_MOTORS.
- tx_data  out  8  byte to the UART transmitter.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_busy  in  1  transmitter busy.
- rx_data  in  8  received byte.
- rx_ready  in  1  received-byte strobe; only its rising edge is used.
- pending  out  10  last-known pending vector, merged with the shadow bits.
- term  out  10  last-known endstop-active vector.
- status_valid  out  1  one-cycle pulse when a good reply has been applied.
- link_err  out  1  one-cycle pulse on reply timeout or malformed reply.

Behaviour:
- Reset: every output is 0. pending resets to 10'h3FF, so every motor counts as busy until the first good poll. The poll timer starts already expired, so the first poll goes out immediately after reset.
- Command frame, 40 bits: {5'b0, dir, steps[14:0], divider[14:0], idx[3:0]}. Transmitted LSB byte first, bytes b0..b4, with b0[3:0] = idx.
- Poll byte is 8'h0F.
- cmd_ready = (state == IDLE) && !poll_due && (cmd_idx >= N_MOTORS || pending[cmd_idx] == 0).
- On acceptance of a valid index:
  - latch the frame;
  - set pending[cmd_idx] = 1 in the same cycle;
  - go to TX_BYTE with byte count 0.
- On acceptance of an invalid index: pulse cmd_rej, stay in IDLE, transmit nothing.
- States:
  - IDLE: if poll_due, go to TX_BYTE with a 1-byte poll. Otherwise accept a command as above. Poll takes priority over a command in the same cycle.
  - TX_BYTE: when tx_busy == 0, drive tx_data, pulse tx_start for 1 cycle, go to TX_WAIT.
  - TX_WAIT: ignore tx_busy for 1 cycle, then wait for tx_busy == 0, load the gap counter with BYTE_GAP, go to GAP.
  - GAP: count down to 0. Then:
    - more bytes to send: go to TX_BYTE;
    - poll finished: clear poll_due, reload the reply timer, go to RX_REPLY;
    - command finished: go to IDLE.
  - RX_REPLY: on each rx_ready rising edge, check the byte against expected byte k (k = 0..3). The byte must satisfy rx_data[7:6] == k and rx_data[5] == 0; store rx_data[4:0].
    - After k == 3: pending = {d1, d0}, term = {d3, d2}, pulse status_valid, go to IDLE.
    - Bad tag, or the timer reaches 0 first: pulse link_err, leave pending and term unchanged, go to IDLE.
- Poll timer: free-running countdown from POLL_PERIOD. When it reaches 0 it sets poll_due and reloads. A poll_due that is already set stays set; polls do not stack.
- rx_ready edges outside RX_REPLY are ignored. Stray bytes are never parsed.
- Command bytes b0..b4 are never interleaved with poll traffic.
- Worst-case inter-byte spacing is well below the controller's 0x3FFFF-cycle receive timeout.
- Reset asserted mid-frame:
  - aborts immediately and all state returns to reset values;
  - tx_start never glitches high during reset.

Decomposition:
- Shared package motor_link_pkg holds:
  - POLL_BYTE = 8'h0F;
  - FRAME_BYTES = 5;
  - REPLY_BYTES = 4;
  - field widths DIV_W = 15, STEP_W = 15, IDX_W = 4;
  - the frame bit offsets (idx 0, divider 4, steps 19, dir 34);
  - the state encoding.
- One sub-module: motor_link_status_rx. It performs rx_ready edge detection, tag checking, the reply timeout and status assembly. It is started by the FSM and returns done/error.

Test Plan:
- Reset, then reply 0x05, 0x5F, 0x81, 0xC0 to the first poll byte 0x0F -> pending = 10'h3E5, term = 10'h001, status_valid pulse.
- Status with pending = 0; command idx = 3, divider = 15'h1234, steps = 15'h0ABC, dir = 1 -> tx bytes 0x43, 0x23, 0xE1, 0x55, 0x04, each followed by a BYTE_GAP gap; pending[3] = 1 after acceptance.
- Second command to idx 3 before the next poll -> cmd_ready stays 0. After a reply with pending[3] = 0 it is accepted and transmitted.
- Command idx = 12 -> cmd_rej pulse, no tx_start.
- Poll with no reply -> link_err after REPLY_TIMEOUT cycles, pending and term unchanged. Poll with reply bytes 0x05, 0x9F -> link_err on the second byte.
- poll_due and cmd_valid in the same IDLE cycle -> 0x0F is sent first and the command follows after the reply. Reset asserted during b2 of a command -> outputs return to reset values, no further tx_start.
